// File: rtl/gaussian_mem_arb.sv
// Two-requester arbiter in front of a single-port pixel RAM for a Gaussian
// filter. The read engine (window fetch) and the writeback engine (filtered
// pixels) share one RAM port. Grants are combinational from the current
// request and the arbitration state. The requester holding the current grant
// streak is the owner. It keeps the port until it has taken BURST_MAX
// consecutive grants while the other side waits, and then the port changes
// hands. Read data returns one cycle after the grant, qualified by rd_valid.
module gaussian_mem_arb #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,        // synchronous, active-low
  // read engine
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  // writeback engine
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  // single-port RAM
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              busy
);

  // Owner encoding: the requester that holds the current grant streak.
  localparam logic [0:0] OWN_RD = 1'b0;
  localparam logic [0:0] OWN_WR = 1'b1;

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  logic [0:0] r_owner;
  logic [3:0] r_cnt;       // grants in the current streak, saturates at BMAX
  logic       r_rd_valid;
  logic       r_busy;

  logic       w_own_req;
  logic       w_oth_req;
  logic       w_gnt_own;
  logic       w_gnt_oth;
  logic       w_gnt_rd;
  logic       w_gnt_wr;
  logic [0:0] w_owner_nxt;
  logic [3:0] w_cnt_nxt;

  // The owner keeps the port while it is under its burst limit, or for as
  // long as the other side is not asking. Otherwise a waiting requester
  // takes over. Nothing is granted while reset is being sampled.
  assign w_own_req = (r_owner == OWN_RD) ? rd_req : wr_req;
  assign w_oth_req = (r_owner == OWN_RD) ? wr_req : rd_req;
  assign w_gnt_own = rst && w_own_req && ((r_cnt < BMAX) || !w_oth_req);
  assign w_gnt_oth = rst && !w_gnt_own && w_oth_req;

  assign w_gnt_rd  = (r_owner == OWN_RD) ? w_gnt_own : w_gnt_oth;
  assign w_gnt_wr  = (r_owner == OWN_WR) ? w_gnt_own : w_gnt_oth;

  assign rd_gnt    = w_gnt_rd;
  assign wr_gnt    = w_gnt_wr;

  // Next owner and streak count: extend on an owner grant, hand over on a
  // grant to the other side, and clear the count when the port is idle.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    if (w_gnt_own) begin
      w_cnt_nxt = (r_cnt < BMAX) ? r_cnt + 4'd1 : BMAX;
    end else if (w_gnt_oth) begin
      w_owner_nxt = ~r_owner;
      w_cnt_nxt   = 4'd1;
    end else begin
      w_cnt_nxt   = 4'd0;
    end
  end

  // Arbitration state, read-return flag and busy flag.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so that every
    // flop samples the values from before this edge, whatever the order of
    // the statements.
    if (!rst) begin
      r_owner    <= OWN_RD;
      r_cnt      <= 4'd0;
      r_rd_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rd_valid <= w_gnt_rd;
      r_busy     <= w_gnt_rd | w_gnt_wr;
    end
  end

  // RAM port steering. Address and write data are zero when the port is idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt_rd) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr;
    end else if (w_gnt_wr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end
  end

  // A read granted just before reset must not return data in the reset
  // cycle, so the flag is also masked by rst. Data is forced to zero
  // whenever it is not valid.
  assign rd_valid = r_rd_valid && rst;
  assign rd_data  = rd_valid ? mem_rdata : '0;
  assign busy     = r_busy;

endmodule
